// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the instruction-fetch queue slice.
//   INST_W     : instruction word width
//   NOP_INST   : word presented to the decoder when a slot is empty
//   FETCH_STEP : word-address advance per fetch request (two words/request)
//   ifq_entry_t: one queue slot, instruction word plus its PC
//   clog2      : ceiling log2 for sizing pointers and the occupancy counter
// ---------------------------------------------------------------------------
package ifq_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = '0;
  localparam int FETCH_STEP = 2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } ifq_entry_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
// Bundles the fetch queue's memory bus, decoder bus and redirect inputs.
//   master modport : the fetch queue
//   slave modport  : the environment (instruction memory + decoder + ALU)
// Signals:
//   jump_en, jump_addr       redirect request and target word address
//   mem_req, mem_addr        fetch request; memory returns mem_addr, +1
//   mem_rdata0, mem_rdata1   returned words, valid the cycle after mem_req
//   out_valid0/1, out_inst0/1, out_pc0/1   two oldest entries to decoder
//   deq_cnt                  words the decoder consumes this cycle (0..2)
//   count                    queue occupancy
// ---------------------------------------------------------------------------
interface ifetch_queue_if #(
  parameter int DEPTH = 8
);
  import ifq_pkg::*;

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic              jump_en;
  logic [31:0]       jump_addr;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [INST_W-1:0] mem_rdata0;
  logic [INST_W-1:0] mem_rdata1;
  logic              out_valid0;
  logic              out_valid1;
  logic [INST_W-1:0] out_inst0;
  logic [INST_W-1:0] out_inst1;
  logic [31:0]       out_pc0;
  logic [31:0]       out_pc1;
  logic [1:0]        deq_cnt;
  logic [CNT_W-1:0]  count;

  modport master (
    input  jump_en, jump_addr, mem_rdata0, mem_rdata1, deq_cnt,
    output mem_req, mem_addr, out_valid0, out_valid1, out_inst0, out_inst1,
           out_pc0, out_pc1, count
  );

  modport slave (
    output jump_en, jump_addr, mem_rdata0, mem_rdata1, deq_cnt,
    input  mem_req, mem_addr, out_valid0, out_valid1, out_inst0, out_inst1,
           out_pc0, out_pc1, count
  );

endinterface

// File: rtl/ifetch_queue_ram.sv
// ---------------------------------------------------------------------------
// ifq_ram
// DEPTH-entry circular storage for the fetch queue. Two write ports land at
// wr_ptr and wr_ptr+1; two combinational read ports return rd_ptr and
// rd_ptr+1. Pointers wrap naturally because DEPTH is a power of two.
// Contents are not reset; occupancy tracking lives in the parent.
//   clk              clock
//   wr_ptr, we0, we1, wdata0, wdata1   write side
//   rd_ptr, rdata0, rdata1             read side
// ---------------------------------------------------------------------------
module ifq_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic             we0,
  input  logic             we1,
  input  ifq_entry_t       wdata0,
  input  ifq_entry_t       wdata1,
  input  logic [PTR_W-1:0] rd_ptr,
  output ifq_entry_t       rdata0,
  output ifq_entry_t       rdata1
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_nxt;
  logic [PTR_W-1:0] rd_nxt;

  assign wr_nxt = wr_ptr + PTR_W'(1);
  assign rd_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (we0) mem[wr_ptr] <= wdata0;
    if (we1) mem[wr_nxt] <= wdata1;
  end

  assign rdata0 = mem[rd_ptr];
  assign rdata1 = mem[rd_nxt];

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// Instruction-fetch producer for the dual-issue decoder. Requests two
// consecutive words per fetch, buffers them with their PCs in a circular
// queue and presents the two oldest entries. The decoder consumes 0..2
// words per cycle; a redirect flushes the queue and restarts fetch.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-low; forces all bus outputs to zero
//   bus  ifetch_queue_if.master (memory bus, decoder bus, redirect)
// Parameters: DEPTH (power of two, >=4), RESET_PC.
// Build option: define IFQ_BYPASS_EN to forward a response straight to the
// decoder when the queue is empty (1-cycle fetch-to-decode latency).
// ---------------------------------------------------------------------------
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master bus
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      req_addr_p1;
  logic             pending;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [CNT_W:0]   occ;
  logic             mem_req;
  logic             bypass;
  logic [1:0]       avail;
  logic [1:0]       deq_eff;
  logic [1:0]       rd_adv;
  logic [1:0]       wr_adv;
  logic             we0;
  logic             we1;
  ifq_entry_t       wdata0;
  ifq_entry_t       wdata1;
  ifq_entry_t       resp0;
  ifq_entry_t       resp1;
  ifq_entry_t       head0;
  ifq_entry_t       head1;
  ifq_entry_t       rd0;
  ifq_entry_t       rd1;
  logic             valid0;
  logic             valid1;

  // Space already promised to the in-flight response counts as used, so a
  // request is only made when two free slots are guaranteed on arrival.
  assign occ     = {1'b0, count} + (pending ? (CNT_W+1)'(2) : (CNT_W+1)'(0));
  assign mem_req = rst && (occ <= (CNT_W+1)'(DEPTH - 2));

  assign resp0 = {bus.mem_rdata0, req_addr_p1};
  assign resp1 = {bus.mem_rdata1, req_addr_p1 + 32'd1};

`ifdef IFQ_BYPASS_EN
  assign bypass = pending && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    avail = 2'd0;
    if (bypass || count >= CNT_W'(2)) avail = 2'd2;
    else if (count != '0)             avail = 2'd1;
    deq_eff = (bus.deq_cnt > avail) ? avail : bus.deq_cnt;

    we0    = 1'b0;
    we1    = 1'b0;
    wdata0 = resp0;
    wdata1 = resp1;
    rd_adv = deq_eff;
    wr_adv = 2'd0;
    if (pending && rst && !bus.jump_en) begin
      if (bypass) begin
        // Words taken straight off the bus are never stored; only the
        // leftovers go in, so rd_ptr stays put and wr_ptr moves by leftovers.
        rd_adv = 2'd0;
        wr_adv = 2'd2 - deq_eff;
        case (deq_eff)
          2'd0: begin
            we0 = 1'b1;
            we1 = 1'b1;
          end
          2'd1: begin
            we0    = 1'b1;
            wdata0 = resp1;
          end
          default: ;
        endcase
      end else begin
        we0    = 1'b1;
        we1    = 1'b1;
        wr_adv = 2'd2;
      end
    end
  end

  ifq_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk    (clk),
    .wr_ptr (wr_ptr),
    .we0    (we0),
    .we1    (we1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rd_ptr (rd_ptr),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  // Stage p0: request issue, queue control
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pending  <= 1'b0;
    end else if (bus.jump_en) begin
      // Clearing pending squashes both the arriving response and the one
      // for any request issued in this same cycle.
      fetch_pc <= bus.jump_addr;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pending  <= 1'b0;
    end else begin
      if (mem_req) fetch_pc <= fetch_pc + 32'(FETCH_STEP);
      pending <= mem_req;
      count   <= count + (pending ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq_eff);
      rd_ptr  <= rd_ptr + PTR_W'(rd_adv);
      wr_ptr  <= wr_ptr + PTR_W'(wr_adv);
    end
  end

  // Stage p1: address of the response arriving this cycle
  always_ff @(posedge clk) begin
    if (mem_req) req_addr_p1 <= fetch_pc;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && bus.deq_cnt > avail) $display("IFQ deq overflow");
  end
`endif

  always_comb begin
    valid0 = rst && (bypass || count != '0);
    valid1 = rst && (bypass || count >= CNT_W'(2));
    head0  = bypass ? resp0 : rd0;
    head1  = bypass ? resp1 : rd1;
    bus.out_valid0 = valid0;
    bus.out_valid1 = valid1;
    bus.out_inst0  = valid0 ? head0.inst : NOP_INST;
    bus.out_inst1  = valid1 ? head1.inst : NOP_INST;
    bus.out_pc0    = valid0 ? head0.pc : 32'h0;
    bus.out_pc1    = valid1 ? head1.pc : 32'h0;
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = rst ? fetch_pc : 32'h0;
  assign bus.count    = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
// Directed bench for ifetch_queue (DEPTH=8, RESET_PC=0). Instruction memory
// returns word_at(addr) for every address. Expected fetch addresses and
// expected consumed words are queued by the stimulus; two monitors pop and
// compare on the falling edge. Build with +define+IFQ_BYPASS_EN to cover
// the bypass variant.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q [$];
  ifq_entry_t  exp_q [$];
  bit          sb_on = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void sb_word(input string name, input logic [31:0] inst,
                                  input logic [31:0] pc);
    ifq_entry_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got pc %h, expected no further word", name, pc);
    end else begin
      e = exp_q.pop_front();
      check({name, " pc"}, pc, e.pc);
      check({name, " inst"}, inst, e.inst);
    end
  endfunction

  // Instruction memory: one-cycle read latency, two words per request
  always @(posedge clk) begin
    bus.mem_rdata0 <= bus.mem_req ? word_at(bus.mem_addr) : 32'hDEAD_0000;
    bus.mem_rdata1 <= bus.mem_req ? word_at(bus.mem_addr + 32'd1) : 32'hDEAD_0001;
  end

  // Fetch address monitor
  always @(negedge clk) begin
    if (rst && bus.mem_req && exp_addr_q.size() > 0)
      check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
  end

  // Decoder-side monitor: checks every word actually consumed
  always @(negedge clk) begin
    if (sb_on && rst && !bus.jump_en) begin
      if (bus.deq_cnt >= 2'd1 && bus.out_valid0)
        sb_word("slot0", bus.out_inst0, bus.out_pc0);
      if (bus.deq_cnt == 2'd2 && bus.out_valid1)
        sb_word("slot1", bus.out_inst1, bus.out_pc1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] nvalid();
    return bus.out_valid1 ? 2'd2 : (bus.out_valid0 ? 2'd1 : 2'd0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] want;
    bus.jump_en   = 1'b0;
    bus.jump_addr = 32'h0;
    bus.deq_cnt   = 2'd0;
    rst           = 1'b0;
    repeat (3) step();

    // Reset state
    check("reset mem_req", 32'(bus.mem_req), 32'h0);
    check("reset out_valid0", 32'(bus.out_valid0), 32'h0);
    check("reset count", 32'(bus.count), 32'h0);

    // Fill with an idle consumer; first cycle over-dequeues an empty queue
    rst = 1'b1;
    bus.deq_cnt = 2'd2;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h2);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h6);
    step();
    bus.deq_cnt = 2'd0;
    check("clamped count", 32'(bus.count), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill count", 32'(bus.count), 32'(2 * k));
    end
    repeat (3) step();
    check("full count", 32'(bus.count), 32'h8);
    check("full mem_req", 32'(bus.mem_req), 32'h0);
    check("fill addrs issued", 32'(exp_addr_q.size()), 32'h0);
    check("full valid1", 32'(bus.out_valid1), 32'h1);
    check("full inst0", bus.out_inst0, word_at(32'h0));
    check("full pc0", bus.out_pc0, 32'h0);
    check("full inst1", bus.out_inst1, word_at(32'h1));
    check("full pc1", bus.out_pc1, 32'h1);

    // Steady two-per-cycle consumption
    for (int i = 0; i < 40; i++) exp_q.push_back({word_at(32'(i)), 32'(i)});
    sb_on = 1'b1;
    repeat (20) begin
      check("steady valid1", 32'(bus.out_valid1), 32'h1);
      bus.deq_cnt = 2'd2;
      step();
    end
    bus.deq_cnt = 2'd0;
    check("steady words consumed", 32'(exp_q.size()), 32'h0);

    // Alternating 1/2 dequeue across many pointer wraps
    for (int i = 40; i < 200; i++) exp_q.push_back({word_at(32'(i)), 32'(i)});
    for (int j = 0; j < 24; j++) begin
      check("odd count bound", 32'(bus.count <= 4'd8), 32'h1);
      want = (j % 2 == 0) ? 2'd1 : 2'd2;
      bus.deq_cnt = (want < nvalid()) ? want : nvalid();
      step();
    end
    bus.deq_cnt = 2'd0;

    // Redirect to 0x100 and fill until count=6 with a response pending
    sb_on = 1'b0;
    exp_q.delete();
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h100;
    step();
    bus.jump_en = 1'b0;
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h102);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h106);
    repeat (4) step();
    check("prejump count", 32'(bus.count), 32'h6);
    check("prejump mem_req", 32'(bus.mem_req), 32'h0);

    // Redirect to 0x40 while a response is in flight
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h40;
    step();
    bus.jump_en = 1'b0;
    check("jump count", 32'(bus.count), 32'h0);
    check("jump valid0", 32'(bus.out_valid0), 32'h0);
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h42);
    for (int i = 32'h40; i < 32'h80; i++) exp_q.push_back({word_at(32'(i)), 32'(i)});
    step();
    check("stale dropped count", 32'(bus.count), 32'h0);
    step();
    check("jump first valid0", 32'(bus.out_valid0), 32'h1);
    check("jump first pc0", bus.out_pc0, 32'h40);
    check("jump first inst0", bus.out_inst0, word_at(32'h40));
    sb_on = 1'b1;
    repeat (6) begin
      bus.deq_cnt = nvalid();
      step();
    end
    bus.deq_cnt = 2'd0;
    sb_on = 1'b0;

    // Reset mid-fill together with a redirect: reset wins
    rst = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_addr = 32'h80;
    #1;
    check("rst mem_req", 32'(bus.mem_req), 32'h0);
    check("rst valid0", 32'(bus.out_valid0), 32'h0);
    check("rst valid1", 32'(bus.out_valid1), 32'h0);
    check("rst inst0", bus.out_inst0, 32'h0);
    check("rst inst1", bus.out_inst1, 32'h0);
    check("rst pc0", bus.out_pc0, 32'h0);
    check("rst pc1", bus.out_pc1, 32'h0);
    step();
    rst = 1'b1;
    bus.jump_en = 1'b0;
    exp_addr_q.push_back(32'h0);
    check("post-rst count", 32'(bus.count), 32'h0);
    step();

    // First response after reset: bypass vs queued latency
`ifdef IFQ_BYPASS_EN
    check("bypass valid0", 32'(bus.out_valid0), 32'h1);
    check("bypass pc0", bus.out_pc0, 32'h0);
    check("bypass inst0", bus.out_inst0, word_at(32'h0));
    bus.deq_cnt = 2'd1;
    step();
    bus.deq_cnt = 2'd0;
    check("bypass count", 32'(bus.count), 32'h1);
    check("bypass left pc0", bus.out_pc0, 32'h1);
    check("bypass left inst0", bus.out_inst0, word_at(32'h1));
    check("bypass left valid1", 32'(bus.out_valid1), 32'h0);
`else
    check("nobypass valid0 early", 32'(bus.out_valid0), 32'h0);
    step();
    check("nobypass valid0", 32'(bus.out_valid0), 32'h1);
    check("nobypass pc0", bus.out_pc0, 32'h0);
    check("nobypass count", 32'(bus.count), 32'h2);
`endif
    check("post-rst addr issued", 32'(exp_addr_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
